nand_page_rd_stream: RTL
========================

// Module: nand_page_rd_stream
// PURPOSE
//  Reader side of the NAND page buffer: walks a range of the dual-port page RAM
//  through one RAM port and emits it as a byte stream with valid/ready handshake
//  toward the NAND program datapath. Bytes leave each 32-bit word little-endian.
//  Prefetches so a continuously-ready sink receives one byte per clock.
// PARAMETERS
//  DATA   32   RAM word width; fixed at 32 (4 bytes/word)
//  ADDR   10   RAM address width
//  DEPTH  517  RAM words; address wraps DEPTH-1 -> 0
//  LEN_W  12   byte-count width
// PORTS
//  clk         in   1      single clock; all logic rising-edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      1-cycle request; sampled only when busy=0
//  start_addr  in   ADDR   first RAM word address
//  byte_len    in   LEN_W  number of bytes to emit
//  abort       in   1      cancel transfer in progress
//  busy        out  1      transfer active
//  done        out  1      1-cycle pulse after last byte handshake
//  mem_addr    out  ADDR   RAM read address (registered)
//  mem_dout    in   DATA   RAM read data, valid 1 clk after mem_addr
//  out_data    out  8      stream byte
//  out_valid   out  1      out_data valid
//  out_ready   in   1      sink accepts byte when out_valid&out_ready
//  out_last    out  1      qualifies final byte of transfer
// BEHAVIOUR
//  Reset: busy=0, done=0, mem_addr=0, out_data=0, out_valid=0, out_last=0, FSM IDLE.
//  FSM: IDLE -start&len!=0-> FETCH -first word captured-> STREAM -last byte taken-> DONE -> IDLE.
//   IDLE -start&len==0-> DONE (done pulses at T+1, no bytes emitted).
//  Latency: start sampled at edge T -> busy=1 and mem_addr=start_addr from T+1;
//   word captured at T+2; out_valid=1 with byte0 (bits 7:0) at T+3.
//  Byte order per word: [7:0],[15:8],[23:16],[31:24]; then next word.
//  Prefetch: one-word buffer; next word address issued while current word drains,
//   so with out_ready held 1 there are zero bubbles, including across words.
//  Address: increments by 1 per word fetched; DEPTH-1 wraps to 0. No read issued
//   for words beyond ceil(byte_len/4) beyond one speculative prefetch (harmless).
//  Partial last word: only byte_len mod 4 bytes (if nonzero) are emitted; rest dropped.
//  Handshake: out_valid, out_data, out_last stable while out_valid&!out_ready;
//   out_valid never drops without a handshake except on abort/reset.
//  out_last=1 only together with out_valid on byte index byte_len-1.
//  done: pulses at cycle after final handshake; busy falls same cycle as done.
//  start while busy=1: ignored. start with abort same cycle in IDLE: ignored.
//  abort while busy: next cycle busy=0, out_valid=0, out_last=0, FSM IDLE, no done.
//  Async reset mid-transfer: all outputs to reset values immediately.
//  Byte counter is LEN_W wide; byte_len up to 2^LEN_W-1 legal (may wrap RAM).
// TESTING
//  RAM[0]=0x44332211,RAM[1]=0x88776655; start addr0 len8, ready=1 -> bytes 11..88
//   on 8 consecutive cycles from T+3, out_last on 0x88, done at next cycle.
//  Same data, len5 -> bytes 11,22,33,44,55; out_last on 55; no 66..88 emitted.
//  start addr515 len12 (RAM[515..516],RAM[0]) -> mem_addr 515,516,0; 12 bytes in order.
//  len8, out_ready toggled 1010.. and held 0 for 5 cycles -> out_data/out_last stable
//   while stalled, no byte lost or duplicated, done after 8th handshake.
//  start len0 -> done=1 at T+1, out_valid never asserted; start during busy ignored.
//  abort after 3 bytes of len8 -> out_valid=0 next cycle, no done; new start len4
//   then streams 4 bytes correctly from its own start_addr.

Source files
------------

// File: rtl/nand_page_rd_stream_if.sv
// Byte stream toward the NAND program datapath: out_data qualified by out_valid,
// taken when out_ready is high; out_last marks the final byte of a transfer.
interface nand_page_rd_stream_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/nand_page_rd_stream.sv
// Walks byte_len bytes of page RAM from start_addr, emitting each word LSB-first; first byte 3 clk after start.
// Two-word buffering keeps a ready sink fed every clk; out_* hold while out_ready is low.
module nand_page_rd_stream #(
  parameter int DATA  = 32,
  parameter int ADDR  = 10,
  parameter int DEPTH = 517,
  parameter int LEN_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR-1:0]       start_addr,
  input  logic [LEN_W-1:0]      byte_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR-1:0]       mem_addr,
  input  logic [DATA-1:0]       mem_dout,
  nand_page_rd_stream_if.master strm
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  state_t           state, state_nxt;
  logic             issue_q;    // read address presented this cycle
  logic             rd_vld;     // mem_dout holds a requested word this cycle
  logic [DATA-1:0]  cur_word, wbuf;
  logic             cur_vld, wbuf_vld;
  logic [1:0]       cur_idx;
  logic [LEN_W-1:0] ld_cnt;     // bytes still to be loaded into the output register
  logic [LEN_W-1:0] fetch_cnt;  // words still to be requested

  logic             start_acc, abort_acc;
  logic [DATA-1:0]  head_word;
  logic             head_vld;
  logic [7:0]       head_byte;
  logic             load_out, head_done, issue;
  logic [2:0]       occ;
  logic [LEN_W:0]   words;
  logic [ADDR-1:0]  addr_inc;

  assign start_acc = (state == IDLE) && start && !abort;
  assign abort_acc = busy && abort;
  assign words     = ({1'b0, byte_len} + (LEN_W+1)'(3)) >> 2;
  assign addr_inc  = (mem_addr == ADDR'(DEPTH-1)) ? '0 : mem_addr + ADDR'(1);

  // Oldest word first: the draining word, else the word arriving from RAM right now.
  always_comb begin
    head_word = cur_vld ? cur_word : mem_dout;
    head_vld  = cur_vld || rd_vld;
    case (cur_idx)
      2'd0:    head_byte = head_word[7:0];
      2'd1:    head_byte = head_word[15:8];
      2'd2:    head_byte = head_word[23:16];
      default: head_byte = head_word[31:24];
    endcase
    load_out  = busy && head_vld && (ld_cnt != '0) && (!strm.out_valid || strm.out_ready);
    head_done = load_out && ((cur_idx == 2'd3) || (ld_cnt == LEN_W'(1)));
    occ       = 3'(cur_vld) + 3'(wbuf_vld) + 3'(rd_vld) + 3'(issue_q) - 3'(head_done);
    issue     = busy && !abort && (fetch_cnt != '0) && (occ < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = (byte_len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (abort)       state_nxt = IDLE;
        else if (rd_vld) state_nxt = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (abort) state_nxt = IDLE;
        else if (strm.out_valid && strm.out_ready && strm.out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr       <= '0;
      issue_q        <= 1'b0;
      rd_vld         <= 1'b0;
      cur_word       <= '0;
      wbuf           <= '0;
      cur_vld        <= 1'b0;
      wbuf_vld       <= 1'b0;
      cur_idx        <= 2'd0;
      ld_cnt         <= '0;
      fetch_cnt      <= '0;
      strm.out_data  <= 8'd0;
      strm.out_valid <= 1'b0;
      strm.out_last  <= 1'b0;
    end else if (abort_acc) begin
      issue_q        <= 1'b0;
      rd_vld         <= 1'b0;
      cur_vld        <= 1'b0;
      wbuf_vld       <= 1'b0;
      cur_idx        <= 2'd0;
      ld_cnt         <= '0;
      fetch_cnt      <= '0;
      strm.out_valid <= 1'b0;
      strm.out_last  <= 1'b0;
    end else if (start_acc && (byte_len != '0)) begin
      mem_addr  <= start_addr;
      issue_q   <= 1'b1;
      rd_vld    <= 1'b0;
      cur_vld   <= 1'b0;
      wbuf_vld  <= 1'b0;
      cur_idx   <= 2'd0;
      ld_cnt    <= byte_len;
      fetch_cnt <= LEN_W'(words - (LEN_W+1)'(1));
    end else begin
      rd_vld  <= issue_q;
      issue_q <= issue;
      if (issue) begin
        mem_addr  <= addr_inc;
        fetch_cnt <= fetch_cnt - LEN_W'(1);
      end

      if (load_out) begin
        strm.out_data  <= head_byte;
        strm.out_valid <= 1'b1;
        strm.out_last  <= (ld_cnt == LEN_W'(1));
        ld_cnt         <= ld_cnt - LEN_W'(1);
      end else if (strm.out_ready) begin
        strm.out_valid <= 1'b0;
        strm.out_last  <= 1'b0;
      end

      // The word arriving from RAM always queues behind whatever is already buffered.
      if (cur_vld) begin
        if (head_done) begin
          cur_idx <= 2'd0;
          if (wbuf_vld) begin
            cur_word <= wbuf;
            wbuf_vld <= rd_vld;
            if (rd_vld) wbuf <= mem_dout;
          end else begin
            cur_vld <= rd_vld;
            if (rd_vld) cur_word <= mem_dout;
          end
        end else begin
          if (load_out) cur_idx <= cur_idx + 2'd1;
          if (rd_vld) begin
            wbuf     <= mem_dout;
            wbuf_vld <= 1'b1;
          end
        end
      end else if (rd_vld) begin
        if (head_done) begin
          cur_idx <= 2'd0;
        end else begin
          cur_word <= mem_dout;
          cur_vld  <= 1'b1;
          cur_idx  <= load_out ? 2'd1 : 2'd0;
        end
      end
    end
  end

endmodule
